posit_mul_sched: RTL and testbench

//  Shares one posit_mul datapath (32-bit posit, ES=3) among NREQ requesters.
//  - Round-robin arbitration; each request is issued to the multiplier as one job.
//  - Result is returned with the requester ID.
//  - A watchdog flushes a hung multiplier and returns NaR with an error flag.

---
 rtl/posit_mul_sched_pkg.sv | 24 ++
 rtl/posit_mul_sched_rr_arbiter.sv | 38 +++
 rtl/posit_mul_sched.sv | 180 ++++++++++++++++++
 tb/tb_posit_mul_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_mul_sched_pkg.sv
// Shared definitions for the posit_mul scheduler: posit constants,
// scheduler FSM encoding and the captured-response record.
package posit_pkg;

  localparam int              POSIT_W    = 32;
  localparam logic [32-1:0]   POSIT_NAR  = 32'h8000_0000;
  localparam logic [32-1:0]   POSIT_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

  // Everything returned to a requester alongside its ID.
  typedef struct packed {
    logic [POSIT_W-1:0] result;
    logic               nar;
    logic               zero;
    logic               err;
  } resp_t;

endpackage

// File: rtl/posit_mul_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Grants the first set request
// at or after ptr, wrapping modulo N, using a double-width priority mask.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] below_ptr;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Mask off requests below ptr in the lower copy; the upper copy supplies the wrap.
  always_comb begin
    // NOTE: every variable written here gets a value before any conditional
    // logic, so no path through the block can leave it unassigned (no latch).
    req_dbl   = {req, req};
    below_ptr = (ONE << ptr) - ONE;
    masked    = req_dbl & ~below_ptr;
    first     = masked & (~masked + ONE);
    gnt       = first[N-1:0] | first[2*N-1:N];
    gnt_id    = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_id = IDW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/posit_mul_sched.sv
// posit_mul_sched: shares one posit_mul datapath among NREQ requesters.
// Round-robin grant, one multiplier job per grant, response tagged with the
// requester ID, and a watchdog that flushes a hung multiplier and answers NaR.
module posit_mul_sched
  import posit_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*POSIT_W-1:0] req_a,
  input  logic [NREQ*POSIT_W-1:0] req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    mul_start,
  output logic [POSIT_W-1:0]      mul_a,
  output logic [POSIT_W-1:0]      mul_b,
  input  logic                    mul_done,
  input  logic [POSIT_W-1:0]      mul_result,
  input  logic                    mul_nar,
  input  logic                    mul_zero,
  output logic                    mul_flush,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [POSIT_W-1:0]      resp_result,
  output logic                    resp_nar,
  output logic                    resp_zero,
  output logic                    resp_err,
  output logic                    busy,
  output logic [7:0]              err_cnt
);

  localparam int             WDW     = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
  localparam logic [7:0]     ERR_MAX = 8'hFF;

  sched_state_e       state_q, state_d;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     id_q;
  logic [POSIT_W-1:0] a_q, b_q;
  resp_t              resp_q;
  logic               done_q;
  logic [WDW-1:0]     wd_q;
  logic [7:0]         err_cnt_q;

  logic [NREQ-1:0]    arb_gnt;
  logic [IDW-1:0]     arb_id;
  logic               arb_any;

  logic               grant;
  logic               capture;
  logic               timeout;
  logic               complete;
  logic               wd_at_limit;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  // Only a fresh rising edge of done counts; a level left over from the
  // previous job is masked by its registered copy.
  assign complete    = mul_done & ~done_q;
  assign wd_at_limit = (wd_q == WD_LAST);

  // Next state and single-cycle strobes; completion beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          grant   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (complete) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else if (wd_at_limit) begin
          timeout = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The grant is combinational from req_valid, so it is held off while reset is asserted.
  assign req_ready   = (grant && !rst) ? arb_gnt : '0;
  assign mul_start   = (state_q == S_ISSUE);
  assign mul_flush   = timeout;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign resp_valid  = (state_q == S_RESP);
  assign resp_id     = id_q;
  assign resp_result = resp_q.result;
  assign resp_nar    = resp_q.nar;
  assign resp_zero   = resp_q.zero;
  assign resp_err    = resp_q.err;
  assign busy        = (state_q != S_IDLE);
  assign err_cnt     = err_cnt_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with <= so every register samples the same
    // pre-edge values regardless of block ordering.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Grant bookkeeping: operands, requester ID and the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the datapath registers are reset too, because they drive outputs
    // that must read zero out of reset; a dropped job leaves nothing behind.
    if (rst) begin
      a_q   <= POSIT_ZERO;
      b_q   <= POSIT_ZERO;
      id_q  <= '0;
      ptr_q <= '0;
    end else if (grant) begin
      a_q   <= req_a[arb_id*POSIT_W +: POSIT_W];
      b_q   <= req_b[arb_id*POSIT_W +: POSIT_W];
      id_q  <= arb_id;
      ptr_q <= (arb_id == LAST_ID) ? '0 : arb_id + 1'b1;
    end
  end

  // Registered copy of mul_done, sampled every cycle for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= mul_done;
  end

  // Watchdog: cleared on issue, counts WAIT cycles up to the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wd_q <= '0;
    end else if (state_q == S_WAIT && !complete && !wd_at_limit) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // Response capture: multiplier outputs on completion, NaR + error on timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q <= '{result: POSIT_ZERO, nar: 1'b0, zero: 1'b0, err: 1'b0};
    end else if (capture) begin
      resp_q <= '{result: mul_result, nar: mul_nar, zero: mul_zero, err: 1'b0};
    end else if (timeout) begin
      resp_q <= '{result: POSIT_NAR, nar: 1'b1, zero: 1'b0, err: 1'b1};
    end
  end

  // Saturating count of watchdog timeouts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_cnt_q <= '0;
    else if (timeout && err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_posit_mul_sched.sv
// Directed bench for posit_mul_sched with a behavioural posit_mul model of
// configurable latency, a held-done mode and a never-completes mode.
`timescale 1ns/1ps
module tb_posit_mul_sched;

  localparam logic [31:0] NAR = 32'h8000_0000;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic         mul_start;
  logic [31:0]  mul_a;
  logic [31:0]  mul_b;
  logic         mul_done;
  logic [31:0]  mul_result;
  logic         mul_nar;
  logic         mul_zero;
  logic         mul_flush;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_result;
  logic         resp_nar;
  logic         resp_zero;
  logic         resp_err;
  logic         busy;
  logic [7:0]   err_cnt;

  posit_mul_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_result  (mul_result),
    .mul_nar     (mul_nar),
    .mul_zero    (mul_zero),
    .mul_flush   (mul_flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_nar    (resp_nar),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- reference multiplier ----------------
  // Returns {result, nar, zero}. 2.0*2.0 is exact (4.0 with es=3 encodes as
  // 0x4800_0000); other operand pairs get a tag that identifies the job.
  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR || b == NAR) return {NAR, 1'b1, 1'b0};
    if (a == 32'h0 || b == 32'h0) return {32'h0, 1'b0, 1'b1};
    if (a == 32'h4400_0000 && b == 32'h4400_0000) return {32'h4800_0000, 2'b00};
    return {a ^ {b[15:0], b[31:16]}, 2'b00};
  endfunction

  int          model_lat    = 3;
  bit          model_hang   = 1'b0;
  bit          model_sticky = 1'b0;
  int          m_cnt;
  bit          m_busy;
  logic [31:0] m_a, m_b;

  // Behavioural posit_mul: done rises model_lat+1 cycles after the start cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_done <= 1'b0; mul_result <= '0; mul_nar <= 1'b0; mul_zero <= 1'b0;
      m_busy <= 1'b0; m_cnt <= 0; m_a <= '0; m_b <= '0;
    end else if (mul_flush) begin
      mul_done <= 1'b0; m_busy <= 1'b0;
    end else if (mul_start) begin
      m_busy <= 1'b1; m_cnt <= model_lat; m_a <= mul_a; m_b <= mul_b;
      if (!model_sticky) mul_done <= 1'b0;
    end else if (m_busy && !model_hang) begin
      if (m_cnt == 1) begin
        mul_done <= 1'b1;
        m_busy   <= 1'b0;
        {mul_result, mul_nar, mul_zero} <= ref_mul(m_a, m_b);
      end else begin
        m_cnt <= m_cnt - 1;
        // Held-done mode: drop done for one cycle just before the new edge.
        if (model_sticky && m_cnt == 2) mul_done <= 1'b0;
      end
    end
  end

  // ---------------- monitor (samples 1 ns before the rising edge) ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_start = 0, n_flush = 0, n_grant = 0, n_multi = 0, n_resp = 0;
  int start_cyc = 0, flush_cyc = 0;
  int grant_q[$];
  int resp_id_q[$];
  logic [31:0] resp_res_q[$];

  always @(negedge clk) begin
    int gid;
    #4;
    if (mul_start === 1'b1) begin n_start++; start_cyc = cyc; end
    if (mul_flush === 1'b1) begin n_flush++; flush_cyc = cyc; end
    if (req_ready !== 4'b0000) begin
      gid = -1;
      for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
      if (!$onehot(req_ready)) n_multi++;
      n_grant++;
      grant_q.push_back(gid);
    end
    if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
      n_resp++;
      resp_id_q.push_back(int'(resp_id));
      resp_res_q.push_back(resp_result);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, output int id);
    int prev;
    int n;
    prev = n_grant;
    n = 0;
    while (n_grant == prev && n < 2000) begin tick(); n++; end
    check({tag, "_granted"}, 128'(n_grant > prev), 128'(1));
    id = (n_grant > prev) ? grant_q[prev] : -1;
  endtask

  task automatic wait_resp(input string tag, output int at);
    int n;
    n = 0;
    while (resp_valid !== 1'b1 && n < 2000) begin tick(); n++; end
    check({tag, "_resp_valid"}, 128'(resp_valid), 128'(1));
    at = cyc;
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({req_ready, mul_start, mul_a, mul_b, mul_flush, resp_valid, resp_id,
                 resp_result, resp_nar, resp_zero, resp_err, busy, err_cnt});
  endfunction

  logic [31:0] op_a [4] = '{32'h4800_0001, 32'h5100_0020, 32'h3A00_0300, 32'h6200_4000};
  logic [31:0] op_b [4] = '{32'h4100_0005, 32'h3300_0060, 32'h2C00_0700, 32'h7700_8000};

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int id, at, g0, f0, r0, bad;
    logic [33:0] exp;
    logic [37:0] snap;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    tick(); tick();
    check("reset_outputs", all_outputs(), 128'(0));
    rst = 1'b0;
    tick();
    check("idle_not_busy", 128'(busy), 128'(0));

    // 1: single requester, 2.0 * 2.0, latency 10.
    model_lat = 10;
    req_a[31:0] = 32'h4400_0000; req_b[31:0] = 32'h4400_0000;
    req_valid = 4'b0001;
    wait_grant("t1", id);
    req_valid = '0;
    check("t1_grant_id", 128'(id), 128'(0));
    wait_resp("t1", at);
    check("t1_resp_id", 128'(resp_id), 128'(0));
    check("t1_result", 128'(resp_result), 128'(32'h4800_0000));
    check("t1_err", 128'(resp_err), 128'(0));
    check("t1_err_cnt", 128'(err_cnt), 128'(0));
    check("t1_latency", 128'(at - start_cyc), 128'(12));
    check("t1_one_start", 128'(n_start), 128'(1));
    tick();
    check("t1_accepted", 128'({resp_valid, busy}), 128'(0));

    // 2: all four requesters held from ptr=0 -> 0,1,2,3,0.
    rst = 1'b1; tick(); rst = 1'b0;
    model_lat = 3;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
    end
    r0 = n_resp;
    g0 = n_grant;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t2", id);
      check($sformatf("t2_grant%0d", k), 128'(id), 128'(k % 4));
    end
    req_valid = '0;
    bad = 0;
    while (n_resp < r0 + 5 && bad < 200) begin tick(); bad++; end
    check("t2_resp_count", 128'(n_resp - r0), 128'(5));
    for (int k = 0; k < 5; k++) begin
      if (n_resp > r0 + k) begin
        exp = ref_mul(op_a[k % 4], op_b[k % 4]);
        check($sformatf("t2_resp_id%0d", k), 128'(resp_id_q[r0 + k]), 128'(grant_q[g0 + k]));
        check($sformatf("t2_resp_res%0d", k), 128'(resp_res_q[r0 + k]), 128'(exp[33:2]));
      end
    end
    check("t2_no_multi_grant", 128'(n_multi), 128'(0));

    // 3: multiplier hangs -> flush 256 cycles after start, NaR with error.
    tick();
    model_hang = 1'b1;
    f0 = n_flush;
    req_valid = 4'b0010;
    wait_grant("t3", id);
    req_valid = '0;
    wait_resp("t3", at);
    check("t3_one_flush", 128'(n_flush - f0), 128'(1));
    check("t3_flush_delay", 128'(flush_cyc - start_cyc), 128'(256));
    check("t3_resp", 128'({resp_id, resp_result, resp_nar, resp_zero, resp_err}),
          128'({2'd1, NAR, 1'b1, 1'b0, 1'b1}));
    check("t3_err_cnt", 128'(err_cnt), 128'(1));
    tick();
    model_hang = 1'b0;

    // 3b: completion lands on the watchdog limit cycle -> completion wins.
    model_lat = 255;
    f0 = n_flush;
    req_valid = 4'b0100;
    wait_grant("t3b", id);
    req_valid = '0;
    wait_resp("t3b", at);
    exp = ref_mul(op_a[2], op_b[2]);
    check("t3b_latency", 128'(at - start_cyc), 128'(257));
    check("t3b_no_flush", 128'(n_flush - f0), 128'(0));
    check("t3b_resp", 128'({resp_result, resp_err}), 128'({exp[33:2], 1'b0}));
    check("t3b_err_cnt", 128'(err_cnt), 128'(1));
    tick();

    // 4: done left high after job 1; job 2 must wait for the new rising edge.
    model_sticky = 1'b1;
    model_lat = 3;
    req_valid = 4'b1000;
    wait_grant("t4a", id);
    req_valid = '0;
    wait_resp("t4a", at);
    tick();
    model_lat = 5;
    req_b[31:0] = 32'h0;
    req_valid = 4'b0001;
    wait_grant("t4b", id);
    req_valid = '0;
    check("t4_grant_id", 128'(id), 128'(0));
    wait_resp("t4b", at);
    check("t4_latency", 128'(at - start_cyc), 128'(7));
    check("t4_resp", 128'({resp_id, resp_result, resp_nar, resp_zero, resp_err}),
          128'({2'd0, 32'h0, 1'b0, 1'b1, 1'b0}));
    tick();
    model_sticky = 1'b0;

    // 5: response held 20 cycles while req1 waits.
    model_lat = 3;
    resp_ready = 1'b0;
    req_valid = 4'b0100;
    wait_grant("t5a", id);
    req_valid = 4'b0010;
    wait_resp("t5a", at);
    snap = {resp_id, resp_result, resp_nar, resp_zero, resp_err};
    g0 = n_grant;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (resp_valid !== 1'b1 || {resp_id, resp_result, resp_nar, resp_zero, resp_err} !== snap) bad++;
    end
    check("t5_stable", 128'(bad), 128'(0));
    check("t5_no_grant_while_held", 128'(n_grant - g0), 128'(0));
    exp = ref_mul(op_a[2], op_b[2]);
    check("t5_held_resp", 128'(snap), 128'({2'd2, exp[33:2], exp[1:0], 1'b0}));
    resp_ready = 1'b1;
    wait_grant("t5b", id);
    req_valid = '0;
    check("t5_req1_grant", 128'(id), 128'(1));
    wait_resp("t5b", at);
    check("t5_req1_resp_id", 128'(resp_id), 128'(1));
    tick();

    // 6: reset in WAIT with req2 and req3 pending (ptr would otherwise favour req3).
    model_hang = 1'b1;
    req_valid = 4'b0100;
    wait_grant("t6a", id);
    req_valid = '0;
    tick(); tick();
    g0 = n_grant;
    req_valid = 4'b1100;
    tick(); tick();
    check("t6_wait_ignores_req", 128'(n_grant - g0), 128'(0));
    check("t6_in_wait_busy", 128'(busy), 128'(1));
    f0 = n_flush;
    r0 = n_resp;
    rst = 1'b1;
    #1;
    check("t6_reset_outputs", all_outputs(), 128'(0));
    tick(); tick();
    model_hang = 1'b0;
    rst = 1'b0;
    wait_grant("t6b", id);
    req_valid = '0;
    check("t6_grant_after_reset", 128'(id), 128'(2));
    wait_resp("t6b", at);
    check("t6_resp", 128'({resp_id, resp_err}), 128'({2'd2, 1'b0}));
    check("t6_no_flush", 128'(n_flush - f0), 128'(0));
    check("t6_err_cnt", 128'(err_cnt), 128'(0));
    tick();
    check("t6_one_resp", 128'(n_resp - r0), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
